// File: rtl/calc_cmd_driver_if.sv
// ---------------------------------------------------------------------------
// calc_cmd_driver_if
//
// Purpose:
//    Bundles the two valid/ready channels of the calculator command driver.
//    The command channel carries accumulator commands into the driver. The
//    response channel carries the resulting accumulator value back out.
//
// Parameters:
//    W          datapath width; must match the driver and the calculator.
//
// Signals:
//    cmd_valid  command present (bus -> driver)
//    cmd_ready  driver can accept a command (driver -> bus)
//    cmd_code   3-bit command code (bus -> driver)
//    cmd_data   W-bit operand D (bus -> driver)
//    rsp_valid  response present (driver -> bus)
//    rsp_ready  consumer accepts the response (bus -> driver)
//    rsp_data   accumulator value after the command (driver -> bus)
//    rsp_ovf    overflow produced by this command (driver -> bus)
//    rsp_err    reserved command code was received (driver -> bus)
//
// Modports:
//    master     the bus / command layer that issues commands
//    slave      the calc_cmd_driver itself
// ---------------------------------------------------------------------------
interface calc_cmd_driver_if #(
   parameter int W = 16
);

   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    cmd_code;
   logic [W-1:0]  cmd_data;

   logic          rsp_valid;
   logic          rsp_ready;
   logic [W-1:0]  rsp_data;
   logic          rsp_ovf;
   logic          rsp_err;

   // The bus side issues commands and consumes responses.
   modport master (
      output cmd_valid,
      output cmd_code,
      output cmd_data,
      input  cmd_ready,
      input  rsp_valid,
      input  rsp_data,
      input  rsp_ovf,
      input  rsp_err,
      output rsp_ready
   );

   // The driver accepts commands and produces responses.
   modport slave (
      input  cmd_valid,
      input  cmd_code,
      input  cmd_data,
      output cmd_ready,
      output rsp_valid,
      output rsp_data,
      output rsp_ovf,
      output rsp_err,
      input  rsp_ready
   );

endinterface

// File: rtl/calc_cmd_driver.sv
// ---------------------------------------------------------------------------
// calc_cmd_driver
//
// Purpose:
//    Sequential command front-end for the team's W-bit combinational
//    calculator. It keeps a W-bit accumulator (ACC), accepts accumulator
//    commands over a valid/ready channel, drives the externally instantiated
//    calculator from registers, captures its result and overflow flag, and
//    returns a response over a second valid/ready channel.
//
//    Each command passes through three states:
//       IDLE  waiting for a command (cmd_ready high)
//       EXEC  the calculator inputs are stable; its result is sampled here
//       RESP  the response is offered until the consumer accepts it
//    With rsp_ready held high this gives one command every three cycles.
//
// Parameters:
//    W      datapath width; must match the attached calculator
//    CNT_W  width of the completed-response counter
//
// Ports:
//    clk         single clock, rising edge
//    rst_n       asynchronous active-low reset
//    bus         command/response channels (calc_cmd_driver_if.slave)
//    ovf_sticky  OR of every rsp_ovf since reset or the last CLR
//    op_count    completed responses, wraps modulo 2^CNT_W
//    calc_op     calculator opcode
//    calc_a      calculator A operand
//    calc_b      calculator B operand
//    calc_r      calculator result (combinational from calc_*)
//    calc_ovf    calculator overflow flag
//
// Command codes (cmd_code):
//    000 ADD   ACC <= ACC + D   (calc 000, A=ACC, B=D)
//    001 SUB   ACC <= ACC - D   (calc 001, A=ACC, B=D)
//    010 RSUB  ACC <= D - ACC   (calc 101, A=ACC, B=D)
//    011 ABS   ACC <= |ACC|     (calc 110, A=ACC, B=0)
//    100 LOAD  ACC <= D
//    101 CLR   ACC <= 0, ovf_sticky <= 0
//    110 READ  ACC unchanged
//    111 reserved: ACC unchanged, rsp_err = 1
// ---------------------------------------------------------------------------
module calc_cmd_driver #(
   parameter int W     = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   calc_cmd_driver_if.slave bus,
   output logic             ovf_sticky,
   output logic [CNT_W-1:0] op_count,
   output logic [2:0]       calc_op,
   output logic [W-1:0]     calc_a,
   output logic [W-1:0]     calc_b,
   input  logic [W-1:0]     calc_r,
   input  logic             calc_ovf
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [2:0] CMD_ADD  = 3'b000;
   localparam logic [2:0] CMD_SUB  = 3'b001;
   localparam logic [2:0] CMD_RSUB = 3'b010;
   localparam logic [2:0] CMD_ABS  = 3'b011;
   localparam logic [2:0] CMD_LOAD = 3'b100;
   localparam logic [2:0] CMD_CLR  = 3'b101;
   localparam logic [2:0] CMD_READ = 3'b110;

   localparam logic [2:0] OP_A_PLUS_B  = 3'b000;
   localparam logic [2:0] OP_A_MINUS_B = 3'b001;
   localparam logic [2:0] OP_B_MINUS_A = 3'b101;
   localparam logic [2:0] OP_ABS_A     = 3'b110;

   logic [1:0]       state_q,      state_d;
   logic [2:0]       code_q,       code_d;
   logic [W-1:0]     data_q,       data_d;
   logic [W-1:0]     acc_q,        acc_d;
   logic [W-1:0]     rsp_data_q,   rsp_data_d;
   logic             rsp_ovf_q,    rsp_ovf_d;
   logic             rsp_err_q,    rsp_err_d;
   logic             ovf_sticky_q, ovf_sticky_d;
   logic [CNT_W-1:0] op_count_q,   op_count_d;
   logic [2:0]       calc_op_q,    calc_op_d;
   logic [W-1:0]     calc_a_q,     calc_a_d;
   logic [W-1:0]     calc_b_q,     calc_b_d;

   logic             cmd_accept;
   logic             rsp_done;
   logic [W-1:0]     exec_acc;
   logic             exec_ovf;
   logic             exec_err;

   // cmd_ready is qualified by rst_n so that no command can be taken while
   // reset is held, even though the state register already reads IDLE.
   assign bus.cmd_ready = rst_n && (state_q == ST_IDLE);
   assign bus.rsp_valid = (state_q == ST_RESP);
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_ovf   = rsp_ovf_q;
   assign bus.rsp_err   = rsp_err_q;

   assign ovf_sticky = ovf_sticky_q;
   assign op_count   = op_count_q;
   assign calc_op    = calc_op_q;
   assign calc_a     = calc_a_q;
   assign calc_b     = calc_b_q;

   assign cmd_accept = bus.cmd_valid && bus.cmd_ready;
   assign rsp_done   = bus.rsp_valid && bus.rsp_ready;

   // Sequencing: IDLE -> EXEC on an accepted command, EXEC -> RESP
   // unconditionally, RESP -> IDLE once the response is taken. Commands
   // presented outside IDLE are simply not acknowledged.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_accept) begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_done) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Command capture. The code and operand are latched on acceptance so the
   // EXEC cycle can finish the command without relying on the bus holding
   // them. The operand is only consumed directly by LOAD; arithmetic
   // commands see it through calc_b.
   always_comb begin
      code_d = code_q;
      data_d = data_q;
      if (cmd_accept) begin
         code_d = bus.cmd_code;
         data_d = bus.cmd_data;
      end
   end

   // Calculator operand registers. They are loaded only for the four
   // arithmetic commands, so the calculator inputs are stable throughout
   // EXEC. For all other commands they keep whatever they held before,
   // since nobody may rely on them outside EXEC.
   always_comb begin
      calc_op_d = calc_op_q;
      calc_a_d  = calc_a_q;
      calc_b_d  = calc_b_q;
      if (cmd_accept) begin
         case (bus.cmd_code)
            CMD_ADD: begin
               calc_op_d = OP_A_PLUS_B;
               calc_a_d  = acc_q;
               calc_b_d  = bus.cmd_data;
            end
            CMD_SUB: begin
               calc_op_d = OP_A_MINUS_B;
               calc_a_d  = acc_q;
               calc_b_d  = bus.cmd_data;
            end
            CMD_RSUB: begin
               calc_op_d = OP_B_MINUS_A;
               calc_a_d  = acc_q;
               calc_b_d  = bus.cmd_data;
            end
            CMD_ABS: begin
               calc_op_d = OP_ABS_A;
               calc_a_d  = acc_q;
               calc_b_d  = '0;
            end
            default: begin
               calc_op_d = calc_op_q;
            end
         endcase
      end
   end

   // Outcome of the latched command as seen during EXEC. Arithmetic commands
   // take the calculator result as-is (wrapped, not saturated) together with
   // its overflow flag; the others never report overflow.
   always_comb begin
      exec_acc = acc_q;
      exec_ovf = 1'b0;
      exec_err = 1'b0;
      case (code_q)
         CMD_ADD, CMD_SUB, CMD_RSUB, CMD_ABS: begin
            exec_acc = calc_r;
            exec_ovf = calc_ovf;
         end
         CMD_LOAD: begin
            exec_acc = data_q;
         end
         CMD_CLR: begin
            exec_acc = '0;
         end
         CMD_READ: begin
            exec_acc = acc_q;
         end
         default: begin
            exec_err = 1'b1;
         end
      endcase
   end

   // Result commit. Everything the response reports is registered at the end
   // of EXEC, so rsp_data/rsp_ovf/rsp_err stay frozen through RESP however
   // long the consumer stalls. CLR wipes the sticky flag instead of ORing.
   always_comb begin
      acc_d        = acc_q;
      rsp_data_d   = rsp_data_q;
      rsp_ovf_d    = rsp_ovf_q;
      rsp_err_d    = rsp_err_q;
      ovf_sticky_d = ovf_sticky_q;
      if (state_q == ST_EXEC) begin
         acc_d      = exec_acc;
         rsp_data_d = exec_acc;
         rsp_ovf_d  = exec_ovf;
         rsp_err_d  = exec_err;
         if (code_q == CMD_CLR) begin
            ovf_sticky_d = 1'b0;
         end else begin
            ovf_sticky_d = ovf_sticky_q | exec_ovf;
         end
      end
   end

   // Completed-response counter; wraps silently at 2^CNT_W.
   always_comb begin
      op_count_d = op_count_q;
      if (rsp_done) begin
         op_count_d = op_count_q + CNT_W'(1);
      end
   end

   // State registers. Reset takes effect immediately and drops any command
   // or response in flight without a handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         code_q       <= '0;
         data_q       <= '0;
         acc_q        <= '0;
         rsp_data_q   <= '0;
         rsp_ovf_q    <= 1'b0;
         rsp_err_q    <= 1'b0;
         ovf_sticky_q <= 1'b0;
         op_count_q   <= '0;
         calc_op_q    <= '0;
         calc_a_q     <= '0;
         calc_b_q     <= '0;
      end else begin
         state_q      <= state_d;
         code_q       <= code_d;
         data_q       <= data_d;
         acc_q        <= acc_d;
         rsp_data_q   <= rsp_data_d;
         rsp_ovf_q    <= rsp_ovf_d;
         rsp_err_q    <= rsp_err_d;
         ovf_sticky_q <= ovf_sticky_d;
         op_count_q   <= op_count_d;
         calc_op_q    <= calc_op_d;
         calc_a_q     <= calc_a_d;
         calc_b_q     <= calc_b_d;
      end
   end

endmodule

// File: tb/tb_calc_cmd_driver.sv
// ---------------------------------------------------------------------------
// tb_calc_cmd_driver
//
// Drives calc_cmd_driver through its command interface with a behavioural
// calculator attached to the calc_* ports. A reference model computes the
// accumulator with plain integer arithmetic and is compared against the DUT
// on every falling edge; directed sequences pin known values, then a
// randomized run exercises all codes with random back-pressure.
// ---------------------------------------------------------------------------
module tb_calc_cmd_driver;

   localparam int W     = 16;
   localparam int CNT_W = 8;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b1;
   logic             ovf_sticky;
   logic [CNT_W-1:0] op_count;
   logic [2:0]       calc_op;
   logic [W-1:0]     calc_a;
   logic [W-1:0]     calc_b;
   logic [W-1:0]     calc_r;
   logic             calc_ovf;

   int compared = 0;
   int failed   = 0;

   bit   readyMode = 1'b0;
   logic readyHold = 1'b1;

   calc_cmd_driver_if #(.W(W)) bus ();

   calc_cmd_driver #(.W(W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .ovf_sticky (ovf_sticky),
      .op_count   (op_count),
      .calc_op    (calc_op),
      .calc_a     (calc_a),
      .calc_b     (calc_b),
      .calc_r     (calc_r),
      .calc_ovf   (calc_ovf)
   );

   always #5 clk = ~clk;

   // Behavioural two's-complement calculator attached to the calc_* ports.
   function automatic logic addOvf(input logic [15:0] x, input logic [15:0] y);
      logic [15:0] s;
      s = x + y;
      return (x[15] == y[15]) && (s[15] != x[15]);
   endfunction

   function automatic logic subOvf(input logic [15:0] x, input logic [15:0] y);
      logic [15:0] s;
      s = x - y;
      return (x[15] != y[15]) && (s[15] != x[15]);
   endfunction

   function automatic logic [15:0] absVal(input logic [15:0] x);
      return x[15] ? 16'(16'h0000 - x) : x;
   endfunction

   always_comb begin
      calc_r   = '0;
      calc_ovf = 1'b0;
      case (calc_op)
         3'b000: begin calc_r = calc_a + calc_b; calc_ovf = addOvf(calc_a, calc_b); end
         3'b001: begin calc_r = calc_a - calc_b; calc_ovf = subOvf(calc_a, calc_b); end
         3'b010, 3'b011: begin calc_r = absVal(calc_b); calc_ovf = (calc_b == 16'h8000); end
         3'b100: begin calc_r = calc_b + calc_a; calc_ovf = addOvf(calc_b, calc_a); end
         3'b101: begin calc_r = calc_b - calc_a; calc_ovf = subOvf(calc_b, calc_a); end
         default: begin calc_r = absVal(calc_a); calc_ovf = (calc_a == 16'h8000); end
      endcase
   end

   // Reference model of one command: new ACC, overflow and error flag,
   // computed with signed integer arithmetic and a range test.
   task automatic modelCmd(input logic [2:0] code, input logic [15:0] d,
                           input logic [15:0] acc, output logic [15:0] nacc,
                           output logic ovf, output logic err);
      int a;
      int dv;
      int s;
      a    = $signed(acc);
      dv   = $signed(d);
      s    = 0;
      nacc = acc;
      ovf  = 1'b0;
      err  = 1'b0;
      case (code)
         3'd0: s = a + dv;
         3'd1: s = a - dv;
         3'd2: s = dv - a;
         3'd3: s = (a < 0) ? -a : a;
         default: s = 0;
      endcase
      if (code <= 3'd3) begin
         ovf  = (s > 32767) || (s < -32768);
         nacc = 16'(s);
      end else if (code == 3'd4) begin
         nacc = d;
      end else if (code == 3'd5) begin
         nacc = 16'h0000;
      end else if (code == 3'd7) begin
         err = 1'b1;
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Single writer of rsp_ready: either a held level or a random level.
   initial begin
      bus.rsp_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.rsp_ready = readyMode ? 1'($urandom_range(0, 1)) : readyHold;
      end
   end

   // Model state and per-cycle compare process.
   int          cyc = 0;
   bit          busy = 1'b0;
   int          acceptCyc = 0;
   logic [15:0] mAcc = '0;
   logic [15:0] accOld = '0;
   logic [15:0] dOld = '0;
   logic [2:0]  codeOld = '0;
   logic [15:0] expData = '0;
   logic        expOvf = 1'b0;
   logic        expErr = 1'b0;
   logic        mSticky = 1'b0;
   logic        stickyNext = 1'b0;
   logic [7:0]  mCount = '0;

   always @(negedge clk) begin
      bit          expValid;
      logic [2:0]  wantOp;
      logic [15:0] wantB;
      if (!rst_n) begin
         checkOutput("rst cmd_ready", 32'(bus.cmd_ready), 0);
         checkOutput("rst rsp_valid", 32'(bus.rsp_valid), 0);
         checkOutput("rst rsp_data", 32'(bus.rsp_data), 0);
         checkOutput("rst rsp_flags", {30'd0, bus.rsp_ovf, bus.rsp_err}, 0);
         checkOutput("rst sticky", 32'(ovf_sticky), 0);
         checkOutput("rst op_count", 32'(op_count), 0);
         checkOutput("rst calc", {calc_op, calc_a[12:0], calc_b}, 0);
         checkOutput("rst calc_a_hi", 32'(calc_a[15:13]), 0);
         busy    = 1'b0;
         mAcc    = '0;
         mSticky = 1'b0;
         mCount  = '0;
      end else begin
         if (busy && cyc == acceptCyc + 2) mSticky = stickyNext;
         expValid = busy && (cyc >= acceptCyc + 2);
         checkOutput("cmd_ready", 32'(bus.cmd_ready), 32'(!busy));
         checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(expValid));
         if (expValid) begin
            checkOutput("rsp_data", 32'(bus.rsp_data), 32'(expData));
            checkOutput("rsp_ovf", 32'(bus.rsp_ovf), 32'(expOvf));
            checkOutput("rsp_err", 32'(bus.rsp_err), 32'(expErr));
         end
         checkOutput("ovf_sticky", 32'(ovf_sticky), 32'(mSticky));
         checkOutput("op_count", 32'(op_count), 32'(mCount));
         if (busy && cyc == acceptCyc + 1 && codeOld <= 3'd3) begin
            wantB = dOld;
            case (codeOld)
               3'd0: wantOp = 3'b000;
               3'd1: wantOp = 3'b001;
               3'd2: wantOp = 3'b101;
               default: begin wantOp = 3'b110; wantB = 16'h0000; end
            endcase
            checkOutput("exec calc_op", 32'(calc_op), 32'(wantOp));
            checkOutput("exec calc_a", 32'(calc_a), 32'(accOld));
            checkOutput("exec calc_b", 32'(calc_b), 32'(wantB));
         end
         if (expValid && bus.rsp_ready) begin
            busy   = 1'b0;
            mCount = mCount + 8'd1;
         end else if (!busy && bus.cmd_valid) begin
            busy      = 1'b1;
            acceptCyc = cyc;
            codeOld   = bus.cmd_code;
            dOld      = bus.cmd_data;
            accOld    = mAcc;
            modelCmd(codeOld, dOld, mAcc, expData, expOvf, expErr);
            mAcc       = expData;
            stickyNext = (codeOld == 3'd5) ? 1'b0 : (mSticky | expOvf);
         end
      end
      cyc++;
   end

   // Presents one command, waits (bounded) for its acceptance and returns
   // the calculator opcode seen during the following EXEC cycle.
   task automatic applyStimulus(input logic [2:0] code, input logic [15:0] d,
                                output logic [2:0] execOp);
      bit got;
      got = 1'b0;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b1;
      bus.cmd_code  = code;
      bus.cmd_data  = d;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (bus.cmd_ready) got = 1'b1;
      end
      if (!got) begin
         compared++;
         failed++;
         $display("[TB] FAIL cmd accept timeout: cmd_ready 0, expected 1 (t=%0t)", $time);
      end
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_code  = 3'($urandom);
      bus.cmd_data  = 16'($urandom);
      @(negedge clk);
      execOp = calc_op;
   endtask

   task automatic waitResponse(output logic [15:0] rd, output logic ro,
                               output logic re, output int lat);
      bit got;
      got = 1'b0;
      lat = 1;
      rd  = '0;
      ro  = 1'b0;
      re  = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         lat++;
         if (bus.rsp_valid) begin
            got = 1'b1;
            rd  = bus.rsp_data;
            ro  = bus.rsp_ovf;
            re  = bus.rsp_err;
         end
      end
      if (!got) begin
         compared++;
         failed++;
         $display("[TB] FAIL rsp timeout: rsp_valid 0, expected 1 (t=%0t)", $time);
      end
   endtask

   task automatic runCmd(input logic [2:0] code, input logic [15:0] d,
                         input logic [15:0] wantData, input logic wantOvf,
                         input logic wantErr, input string tag,
                         output logic [2:0] execOp);
      logic [15:0] rd;
      logic        ro;
      logic        re;
      int          lat;
      applyStimulus(code, d, execOp);
      waitResponse(rd, ro, re, lat);
      checkOutput({tag, " data"}, 32'(rd), 32'(wantData));
      checkOutput({tag, " ovf"}, 32'(ro), 32'(wantOvf));
      checkOutput({tag, " err"}, 32'(re), 32'(wantErr));
      checkOutput({tag, " latency"}, 32'(lat), 2);
   endtask

   initial begin
      logic [2:0]  op;
      logic [15:0] d0;
      logic [15:0] rd;
      logic [2:0]  rc;
      bus.cmd_valid = 1'b0;
      bus.cmd_code  = '0;
      bus.cmd_data  = '0;

      #1 rst_n = 1'b0;
      #3;
      checkOutput("reset cmd_ready", 32'(bus.cmd_ready), 0);
      checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 0);
      checkOutput("reset op_count", 32'(op_count), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      runCmd(3'd4, 16'h0005, 16'h0005, 1'b0, 1'b0, "LOAD5", op);
      runCmd(3'd0, 16'h0003, 16'h0008, 1'b0, 1'b0, "ADD3", op);
      @(posedge clk);
      #1;
      checkOutput("op_count after two", 32'(op_count), 2);

      runCmd(3'd4, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, "LOAD7FFF", op);
      runCmd(3'd0, 16'h0001, 16'h8000, 1'b1, 1'b0, "ADD ovf", op);
      checkOutput("sticky after ovf", 32'(ovf_sticky), 1);
      runCmd(3'd6, 16'h1111, 16'h8000, 1'b0, 1'b0, "READ", op);
      checkOutput("sticky after READ", 32'(ovf_sticky), 1);
      runCmd(3'd5, 16'h2222, 16'h0000, 1'b0, 1'b0, "CLR", op);
      checkOutput("sticky after CLR", 32'(ovf_sticky), 0);

      runCmd(3'd4, 16'h0002, 16'h0002, 1'b0, 1'b0, "LOAD2", op);
      runCmd(3'd2, 16'h0009, 16'h0007, 1'b0, 1'b0, "RSUB9", op);
      checkOutput("RSUB exec op", 32'(op), 32'(3'b101));
      runCmd(3'd1, 16'h000A, 16'hFFFD, 1'b0, 1'b0, "SUBA", op);
      runCmd(3'd3, 16'h0000, 16'h0003, 1'b0, 1'b0, "ABS", op);
      checkOutput("ABS exec op", 32'(op), 32'(3'b110));

      runCmd(3'd4, 16'h8000, 16'h8000, 1'b0, 1'b0, "LOAD8000", op);
      runCmd(3'd3, 16'h0000, 16'h8000, 1'b1, 1'b0, "ABS min", op);
      runCmd(3'd7, 16'h1234, 16'h8000, 1'b0, 1'b1, "reserved", op);
      runCmd(3'd6, 16'h0000, 16'h8000, 1'b0, 1'b0, "READ after err", op);

      // Stalled response with an ignored command pulse.
      readyHold = 1'b0;
      applyStimulus(3'd0, 16'h0001, op);
      @(negedge clk);
      d0 = bus.rsp_data;
      checkOutput("stall data", 32'(d0), 32'h8001);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         bus.cmd_valid = (i == 4);
         bus.cmd_code  = 3'd4;
         bus.cmd_data  = 16'h1234;
         @(negedge clk);
         checkOutput("stall rsp_valid", 32'(bus.rsp_valid), 1);
         checkOutput("stall rsp_data", 32'(bus.rsp_data), 32'(d0));
         checkOutput("stall cmd_ready", 32'(bus.cmd_ready), 0);
      end
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      readyHold     = 1'b1;
      runCmd(3'd6, 16'h0000, 16'h8001, 1'b0, 1'b0, "READ after stall", op);

      // Reset while a command is in EXEC.
      applyStimulus(3'd0, 16'h0005, op);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("midrst rsp_valid", 32'(bus.rsp_valid), 0);
      checkOutput("midrst cmd_ready", 32'(bus.cmd_ready), 0);
      checkOutput("midrst rsp_data", 32'(bus.rsp_data), 0);
      checkOutput("midrst calc", {13'd0, calc_op, calc_a}, 0);
      checkOutput("midrst calc_b", 32'(calc_b), 0);
      checkOutput("midrst op_count", 32'(op_count), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      runCmd(3'd6, 16'h0000, 16'h0000, 1'b0, 1'b0, "READ after rst", op);
      @(posedge clk);
      #1;
      checkOutput("op_count after rst", 32'(op_count), 1);

      // Randomized run with random back-pressure; enough commands to wrap op_count.
      readyMode = 1'b1;
      for (int n = 0; n < 300; n++) begin
         rc = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 7))
            0: rd = 16'h7FFF;
            1: rd = 16'h8000;
            2: rd = 16'h0001;
            3: rd = 16'hFFFF;
            default: rd = 16'($urandom);
         endcase
         applyStimulus(rc, rd, op);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      readyMode = 1'b0;
      readyHold = 1'b1;
      repeat (10) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
